// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: a main slot plus one skid slot behind valid/ready handshakes.
// The skid slot decouples in_ready from out_ready so it can still run at full throughput.
module pipe_skid_stage #(
    parameter int WIDTH      = 32,
    parameter int FLUSH_ZERO = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     main_q, main_d;
    logic [WIDTH-1:0]     skid_q, skid_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic                 in_xfer;
    logic                 out_xfer;

    assign in_ready  = !rst && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        // The stall counter keeps counting through a flush and sticks at all-ones.
        if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end

        if (flush) begin
            state_d = EMPTY;
            if (FLUSH_ZERO != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: a vector table plus stall-saturation and FIFO-order sequences.
module tb_pipe_skid_stage;

    localparam int W  = 8;
    localparam int CW = 3;
    localparam int NV = 31;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  inData;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  outData;
    logic [1:0]    occupancy;
    logic [CW-1:0] stallCnt;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic          rst;
        logic          flush;
        logic          inValid;
        logic [W-1:0]  inData;
        logic          outReady;
        logic          expValid;
        logic [W-1:0]  expData;
        logic          expReady;
        logic [1:0]    expOcc;
        logic [CW-1:0] expStall;
    } vec_t;

    vec_t vecs[NV];

    pipe_skid_stage #(
        .WIDTH      (W),
        .FLUSH_ZERO (1),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .occupancy (occupancy),
        .stall_cnt (stallCnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic r, input logic f, input logic iv, input logic [W-1:0] id,
                                   input logic orr, input logic ev, input logic [W-1:0] ed,
                                   input logic er, input logic [1:0] eo, input logic [CW-1:0] es);
        vec_t v;
        v.rst = r; v.flush = f; v.inValid = iv; v.inData = id; v.outReady = orr;
        v.expValid = ev; v.expData = ed; v.expReady = er; v.expOcc = eo; v.expStall = es;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic iv, input logic [W-1:0] id, input logic orr);
        @(negedge clk);
        rst      = r;
        flush    = f;
        inValid  = iv;
        inData   = id;
        outReady = orr;
    endtask

    logic [W-1:0] expQ[$];
    logic [W-1:0] frontVal;
    int           sent;
    int           rcvd;
    int           expStall;

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;

        //                  rst flush iv  data   or   ov  data   ir  occ  stall
        vecs[0]  = mkVec(1, 0, 0, 8'h00, 0,  0, 8'h00, 0, 2'd0, 3'd0);
        vecs[1]  = mkVec(1, 0, 0, 8'h00, 0,  0, 8'h00, 0, 2'd0, 3'd0);
        vecs[2]  = mkVec(0, 0, 1, 8'h11, 1,  1, 8'h11, 1, 2'd1, 3'd0);
        vecs[3]  = mkVec(0, 0, 1, 8'h22, 1,  1, 8'h22, 1, 2'd1, 3'd0);
        vecs[4]  = mkVec(0, 0, 1, 8'h33, 1,  1, 8'h33, 1, 2'd1, 3'd0);
        vecs[5]  = mkVec(0, 0, 0, 8'h00, 1,  0, 8'h33, 1, 2'd0, 3'd0);
        vecs[6]  = mkVec(0, 0, 1, 8'h0A, 0,  1, 8'h0A, 1, 2'd1, 3'd0);
        vecs[7]  = mkVec(0, 0, 1, 8'h0B, 0,  1, 8'h0A, 0, 2'd2, 3'd1);
        vecs[8]  = mkVec(0, 0, 1, 8'h0C, 0,  1, 8'h0A, 0, 2'd2, 3'd2);
        vecs[9]  = mkVec(0, 0, 0, 8'h00, 1,  1, 8'h0B, 1, 2'd1, 3'd2);
        vecs[10] = mkVec(0, 0, 0, 8'h00, 1,  0, 8'h0B, 1, 2'd0, 3'd2);
        vecs[11] = mkVec(0, 0, 1, 8'h05, 0,  1, 8'h05, 1, 2'd1, 3'd2);
        vecs[12] = mkVec(0, 0, 1, 8'h06, 1,  1, 8'h06, 1, 2'd1, 3'd2);
        vecs[13] = mkVec(0, 0, 0, 8'h00, 1,  0, 8'h06, 1, 2'd0, 3'd2);
        vecs[14] = mkVec(0, 0, 1, 8'h0D, 0,  1, 8'h0D, 1, 2'd1, 3'd2);
        vecs[15] = mkVec(0, 0, 1, 8'h0E, 0,  1, 8'h0D, 0, 2'd2, 3'd3);
        vecs[16] = mkVec(0, 1, 1, 8'h0F, 0,  0, 8'h00, 1, 2'd0, 3'd4);
        vecs[17] = mkVec(0, 0, 1, 8'h21, 0,  1, 8'h21, 1, 2'd1, 3'd4);
        vecs[18] = mkVec(0, 1, 1, 8'h77, 0,  0, 8'h00, 1, 2'd0, 3'd5);
        vecs[19] = mkVec(0, 0, 0, 8'h00, 1,  0, 8'h00, 1, 2'd0, 3'd5);
        vecs[20] = mkVec(0, 0, 1, 8'h44, 0,  1, 8'h44, 1, 2'd1, 3'd5);
        vecs[21] = mkVec(0, 0, 0, 8'h00, 0,  1, 8'h44, 1, 2'd1, 3'd6);
        vecs[22] = mkVec(0, 0, 0, 8'h00, 0,  1, 8'h44, 1, 2'd1, 3'd7);
        vecs[23] = mkVec(0, 0, 0, 8'h00, 0,  1, 8'h44, 1, 2'd1, 3'd7);
        vecs[24] = mkVec(0, 0, 0, 8'h00, 0,  1, 8'h44, 1, 2'd1, 3'd7);
        vecs[25] = mkVec(0, 1, 0, 8'h00, 0,  0, 8'h00, 1, 2'd0, 3'd7);
        vecs[26] = mkVec(1, 0, 0, 8'h00, 0,  0, 8'h00, 0, 2'd0, 3'd0);
        vecs[27] = mkVec(0, 0, 1, 8'h55, 0,  1, 8'h55, 1, 2'd1, 3'd0);
        vecs[28] = mkVec(0, 0, 1, 8'h66, 0,  1, 8'h55, 0, 2'd2, 3'd1);
        vecs[29] = mkVec(1, 0, 1, 8'h77, 0,  0, 8'h00, 0, 2'd0, 3'd0);
        vecs[30] = mkVec(0, 0, 0, 8'h00, 0,  0, 8'h00, 1, 2'd0, 3'd0);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].inValid, vecs[i].inData, vecs[i].outReady);
            @(posedge clk);
            #1;
            checkOutput("out_valid", i, 32'(outValid),  32'(vecs[i].expValid));
            checkOutput("out_data",  i, 32'(outData),   32'(vecs[i].expData));
            checkOutput("in_ready",  i, 32'(inReady),   32'(vecs[i].expReady));
            checkOutput("occupancy", i, 32'(occupancy), 32'(vecs[i].expOcc));
            checkOutput("stall_cnt", i, 32'(stallCnt),  32'(vecs[i].expStall));
        end

        // Ten stalled cycles must pin the counter at 7; flush keeps it, reset clears it.
        applyStimulus(1, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 1, 8'h99, 0);
        @(posedge clk);
        #1;
        checkOutput("sat_load_occ", 0, 32'(occupancy), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0);
            @(posedge clk);
            #1;
            expStall = (i > 7) ? 7 : i;
            checkOutput("sat_stall_cnt", i, 32'(stallCnt), 32'(expStall));
            checkOutput("sat_out_data",  i, 32'(outData),  32'h99);
        end
        applyStimulus(0, 1, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        checkOutput("sat_after_flush", 0, 32'(stallCnt), 32'd7);
        checkOutput("sat_flush_valid", 0, 32'(outValid), 32'd0);
        applyStimulus(1, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        checkOutput("sat_after_rst", 0, 32'(stallCnt), 32'd0);
        checkOutput("rst_in_ready",  0, 32'(inReady),  32'd0);

        // Irregular valid/ready pattern against a FIFO model: order and count must survive.
        applyStimulus(0, 0, 0, 8'h00, 0);
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            outReady = (c % 3 != 1);
            inValid  = (sent < 8) && (c % 4 != 3);
            inData   = W'(8'hC0 + sent);
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("fifo_unexpected_out", c, 32'(outData), 32'hFFFF_FFFF);
                end else begin
                    frontVal = expQ.pop_front();
                    checkOutput("fifo_order", c, 32'(outData), 32'(frontVal));
                    rcvd++;
                end
            end
            if (inValid && inReady) begin
                expQ.push_back(inData);
                sent++;
            end
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b0;
        checkOutput("fifo_sent",     0, 32'(sent),        32'd8);
        checkOutput("fifo_received", 0, 32'(rcvd),        32'd8);
        checkOutput("fifo_drained",  0, 32'(expQ.size()), 32'd0);
        checkOutput("fifo_empty",    0, 32'(occupancy),   32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, elastic successor to the fixed-payload pipeline stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque WIDTH-bit payload, such as a packed pipeline struct cast to bits, using valid/ready handshakes on both sides.
- A 2-entry skid buffer gives full throughput with no combinational path from out_ready to in_ready.
- Adds flush (bubble insertion), in-order delivery and a saturating downstream-stall counter for performance debug.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- FLUSH_ZERO, 1, 1 = payload registers cleared to '0 on flush; 0 = payload retained and only valids cleared.
- CNT_WIDTH, 16, width of stall_cnt (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and any same-cycle input transfer.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; in transfer = in_valid & in_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  main slot holds valid entry.
- out_ready  in  1  downstream accepts; out transfer = out_valid & out_ready.
- out_data  out  WIDTH  main-slot payload.
- occupancy  out  2  held entries: 0, 1 or 2.
- stall_cnt  out  CNT_WIDTH  cycles with out_valid & !out_ready, saturating.

Behaviour:
- Storage: main slot (drives out_data/out_valid) and skid slot. State EMPTY (0 held), BUSY (main only), FULL (main+skid). Outputs are direct register values; occupancy encodes the state.
- in_ready = !rst & (state != FULL). It is a function of registered state and rst only, never of out_ready or in_valid.
- Reset (priority 1): next state EMPTY; main, skid and stall_cnt cleared to 0. During reset: out_valid=0, out_data='0, in_ready=0, occupancy=0. Reset mid-transfer discards all entries silently.
- Flush (priority 2, when !rst): next state EMPTY.
  - An in transfer in the flush cycle is discarded.
  - An out transfer in the flush cycle counts as delivered (downstream consumed it).
  - Payload slots are zeroed iff FLUSH_ZERO=1.
  - stall_cnt is not affected by flush.
- Normal transitions (i = in transfer, o = out transfer):
  - EMPTY: i → BUSY, main<=in_data; else stay. (o is impossible.)
  - BUSY: i&o → BUSY, main<=in_data. i&!o → FULL, skid<=in_data. !i&o → EMPTY. Neither → hold.
  - FULL: i is impossible. o → BUSY, main<=skid. Else hold.
- Latency: 1 cycle from in transfer to out_valid when EMPTY. Throughput is 1 transfer/cycle sustained when out_ready=1.
- Order: strict FIFO. The skid entry is always older-than-new and younger than main.
- Entries are never dropped or duplicated except by rst or flush.
- out_data is stable while out_valid & !out_ready; no entry changes without an out transfer.
- stall_cnt: +1 each cycle out_valid & !out_ready (sampled pre-edge). Saturates at 2^CNT_WIDTH-1 and holds there. Cleared only by rst.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 with data 0x11, 0x22, 0x33 on consecutive cycles, out_ready=1 → out_data 0x11/0x22/0x33 on cycles 1-3 after first accept; in_ready stays 1; occupancy=1; stall_cnt=0.
- Backpressure fill: out_ready=0; send 0xA, 0xB → occupancy 2, in_ready=0, out_data=0xA held. Raise out_ready → 0xA then 0xB delivered in order; in_ready returns 1 one cycle after the first out transfer; stall_cnt equals the number of stalled cycles.
- Simultaneous in/out in BUSY: main=0x5, in_data=0x6, in_valid=out_ready=1 → next cycle out_data=0x6, occupancy 1, nothing lost.
- Flush while FULL with concurrent in_valid (in_ready=0) and while BUSY with concurrent in transfer 0x77 → next cycle out_valid=0, occupancy 0; out_data='0 with FLUSH_ZERO=1; 0x77 never appears.
- Saturation: CNT_WIDTH=3, hold out_valid=1, out_ready=0 for 10 cycles → stall_cnt reaches 7 and stays 7. Flush leaves it at 7; rst clears it to 0.
- Reset mid-FULL: occupancy 2, assert rst 1 cycle → in_ready=0 during rst; afterwards out_valid=0, occupancy 0, in_ready=1.
